// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch redirect, flush and halt controller with branch statistics
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   load_use_hazard           hazard unit asks to hold IF
//   halt_req, resume          halt request / release pulses
//   br_valid, br_pc, br_taken, br_target
//                             branch resolved in EX this cycle
//   pred_taken, pred_target   prediction carried down with that branch
//   pc_en, pc_stall           PC register enable / hold request
//   isbj, succeed, g_addr     predictor update strobe, outcome and corrected next address
//   flush_if, flush_id        kill IF/ID and ID/EX registers
//   halted                    controller sits in HALT
//   br_cnt, miss_cnt          saturating resolved-branch / mispredict counters
module fetch_redirect_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_hazard,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              pc_en,
  output logic              pc_stall,
  output logic              isbj,
  output logic              succeed,
  output logic [ADDR_W-1:0] g_addr,
  output logic              flush_if,
  output logic              flush_id,
  output logic              halted,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  // The mispredict cycle is itself a flush cycle, so FLUSH lasts FLUSH_CYC
  // more cycles: the counter counts down from FLUSH_CYC-1 to 0.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  state_t      state, state_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;
  logic        halt_pend, halt_pend_nxt;
  logic        accept;
  logic        mispredict;

  // A not-taken branch is correct on direction alone; the target only matters when taken.
  assign succeed    = (pred_taken == br_taken) && (!br_taken || (pred_target == br_target));
  assign g_addr     = br_taken ? br_target : br_pc + ADDR_W'(1);
  assign accept     = br_valid && (state == S_RUN);
  assign mispredict = accept && !succeed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      flush_cnt <= 3'd0;
      halt_pend <= 1'b0;
      br_cnt    <= '0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      halt_pend <= halt_pend_nxt;
      if (accept && (br_cnt != '1)) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (mispredict && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    halt_pend_nxt = halt_pend;
    case (state)
      S_RUN: begin
        if (mispredict) begin
          // The redirect wins; a coincident halt request is remembered for after the flush.
          state_nxt     = S_FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
          halt_pend_nxt = halt_req;
        end else if (halt_req) begin
          state_nxt = S_HALT;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == 3'd0) begin
          state_nxt = (halt_pend || halt_req) ? S_HALT : S_RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      S_HALT: begin
        halt_pend_nxt = 1'b0;
        if (resume) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    pc_en    = 1'b1;
    pc_stall = 1'b0;
    isbj     = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    halted   = 1'b0;
    case (state)
      S_RUN: begin
        isbj = accept;
        if (mispredict) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else begin
          pc_stall = load_use_hazard;
        end
      end
      S_FLUSH: begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end
      S_HALT: begin
        pc_en    = 1'b0;
        pc_stall = 1'b1;
        halted   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
